ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (8-bit data, 1-cycle read latency) among
//  three requesters: video fetch, Z80 CPU and tape/ROM loader. Pipelined; accepts
//  at most one access per clock. Sits between the requesters and the RAM's
//  read/write port.
// PARAMETERS
//  ADDR_WIDTH      16  address width of all ports
//  DATA_WIDTH      8   data width of all ports
//  VIDEO_PRIORITY  1   1: video has fixed top priority, CPU/loader round-robin;
//                      0: three-way round-robin
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  reset      in   1           asynchronous, active-high
//  vid_req    in   1           video read request, level, held until vid_ack
//  vid_addr   in   ADDR_WIDTH  video read address
//  vid_ack    out  1           one-cycle pulse: vid_rdata valid
//  vid_rdata  out  DATA_WIDTH  read data
//  cpu_req    in   1           CPU request, level, held until cpu_ack
//  cpu_we     in   1           1 = write, 0 = read
//  cpu_addr   in   ADDR_WIDTH  CPU address
//  cpu_wdata  in   DATA_WIDTH  CPU write data
//  cpu_ack    out  1           one-cycle pulse: access done / cpu_rdata valid
//  cpu_rdata  out  DATA_WIDTH  read data
//  ldr_req    in   1           loader request, level, held until ldr_ack
//  ldr_we     in   1           1 = write, 0 = read
//  ldr_addr   in   ADDR_WIDTH  loader address
//  ldr_wdata  in   DATA_WIDTH  loader write data
//  ldr_ack    out  1           one-cycle pulse: access done / ldr_rdata valid
//  ldr_rdata  out  DATA_WIDTH  read data
//  mem_addr   out  ADDR_WIDTH  RAM address (registered)
//  mem_we     out  1           RAM write enable (registered)
//  mem_wdata  out  DATA_WIDTH  RAM write data (registered)
//  mem_rdata  in   DATA_WIDTH  RAM read data, valid 1 cycle after mem_addr
// BEHAVIOUR
//  - Reset: mem_addr/mem_wdata = 0, mem_we = 0, all acks = 0, all pending bits = 0,
//    pipeline empty. Round-robin state set so the CPU wins the first tie.
//  - Eligibility: req & ~pending[i]. A requester has at most one access in flight.
//  - Cycle N (grant): pick a winner among eligible requesters. Register its
//    addr/we/wdata onto mem_*; set pending[w]; push the winner id into stage 1.
//    If nothing is eligible: mem_we <= 0, stage 1 empty, mem_addr holds its value.
//  - Cycle N+1: RAM sees mem_*. A write is performed at this edge; mem_we is high
//    for exactly this one cycle.
//  - Cycle N+2: ack[w] = 1 for one cycle. rdata = mem_rdata, driven combinationally
//    to all three rdata ports and valid only with the matching ack. pending[w]
//    clears at the end of N+2. Writes also ack at N+2; rdata is don't-care for
//    writes.
//  - req sampled high in the cycle after its ack is a new request. Requesters
//    therefore drop req in N+3 unless they want another access.
//  - Priority with VIDEO_PRIORITY=1: eligible video always wins. Otherwise CPU vs
//    loader: a sole eligible one wins. On a tie, the one not last granted between
//    the two wins. Video grants do not change the CPU/loader state.
//  - Priority with VIDEO_PRIORITY=0: rotating pointer over {cpu, ldr, vid} in that
//    order. Search starts after the last winner.
//  - Throughput: one grant per cycle. Any single requester gets at most one grant
//    per 3 cycles, because of pending.
//  - Address/data are captured only at grant. Changes after grant have no effect.
//  - Reset mid-operation: asserting reset clears everything immediately. An access
//    registered but not yet seen by the RAM has mem_we forced to 0 and never acks.
//    Requesters re-request after reset is released.
//  - No ack is ever generated without a preceding grant. Acks of different
//    requesters are never high in the same cycle.
// TESTING
//  1 RAM model [0x4000]=0x5A; cpu_req read 0x4000 sampled at c0 -> mem_addr=0x4000
//    in c1, cpu_ack=1 and cpu_rdata=0x5A in c2 only, single pulse.
//  2 VIDEO_PRIORITY=1; vid/cpu/ldr reads all raised at c0 and held to ack ->
//    grants vid c0, cpu c1, ldr c2; acks vid c2, cpu c3, ldr c4.
//  3 ldr write 0x8000<=0xC3, then cpu read 0x8000 -> mem_we high exactly 1 cycle
//    with mem_wdata=0xC3; cpu_rdata=0xC3 at cpu_ack.
//  4 cpu and ldr req held high continuously, video idle, for 20 cycles ->
//    alternating grants; each acks every 3 cycles at most; no two acks coincide.
//  5 VIDEO_PRIORITY=0; all three held continuously -> grant order cpu, ldr, vid
//    repeating, one grant per cycle.
//  6 cpu write granted at c0, reset pulsed in c1 -> mem_we=0 and all acks 0
//    immediately; no ack after release; a new cpu read completes with 2-cycle
//    latency.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: three requesters (video, CPU, loader) share one single-port
// synchronous RAM with 1-cycle read latency. One grant per clock. A grant in
// cycle N drives mem_* in N+1, and the winner's ack pulses in N+2. Each
// requester has at most one access in flight, tracked by its pending bit.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter bit          VIDEO_PRIORITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Requester identifiers; the encoding doubles as the bit index into
    // pending/ack vectors and as the round-robin order cpu -> ldr -> vid.
    typedef enum logic [1:0] {
        ID_CPU = 2'd0,
        ID_LDR = 2'd1,
        ID_VID = 2'd2
    } req_id_t;

    logic [2:0]            r_pending;
    logic [2:0]            r_ack;
    logic                  r_s1_vld;
    req_id_t               r_s1_id;
    logic                  r_cl_last_ldr;   // 1: loader won the last CPU/loader decision
    req_id_t               r_rr_last;       // last winner for three-way rotation

    logic [2:0]            w_req;
    logic [2:0]            w_elig;
    logic                  w_grant_vld;
    req_id_t               w_grant_id;
    logic [2:0]            w_grant_oh;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_gnt_we;
    logic [DATA_WIDTH-1:0] w_gnt_wdata;
    int unsigned           w_cand;

    assign w_req  = {vid_req, ldr_req, cpu_req};
    assign w_elig = w_req & ~r_pending;

    // Winner selection among eligible requesters for this cycle.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = ID_CPU;
        w_cand      = 0;
        if (VIDEO_PRIORITY) begin
            if (w_elig[ID_VID]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_VID;
            end else if (w_elig[ID_CPU] && w_elig[ID_LDR]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = r_cl_last_ldr ? ID_CPU : ID_LDR;
            end else if (w_elig[ID_CPU]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_CPU;
            end else if (w_elig[ID_LDR]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_LDR;
            end
        end else begin
            // Search starts at the requester after the last winner.
            for (int unsigned k = 1; k <= 3; k++) begin
                w_cand = ({30'd0, r_rr_last} + k) % 3;
                if (!w_grant_vld && w_elig[w_cand[1:0]]) begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = req_id_t'(w_cand[1:0]);
                end
            end
        end
    end

    // Winner's one-hot and its access fields.
    always_comb begin
        w_grant_oh  = '0;
        w_gnt_addr  = cpu_addr;
        w_gnt_we    = cpu_we;
        w_gnt_wdata = cpu_wdata;
        if (w_grant_vld) begin
            w_grant_oh[w_grant_id] = 1'b1;
        end
        case (w_grant_id)
            ID_LDR: begin
                w_gnt_addr  = ldr_addr;
                w_gnt_we    = ldr_we;
                w_gnt_wdata = ldr_wdata;
            end
            ID_VID: begin
                w_gnt_addr  = vid_addr;
                w_gnt_we    = 1'b0;
                w_gnt_wdata = '0;
            end
            default: begin
                w_gnt_addr  = cpu_addr;
                w_gnt_we    = cpu_we;
                w_gnt_wdata = cpu_wdata;
            end
        endcase
    end

    // RAM port registers: capture the winner's access; idle cycles hold the address and drop write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (w_grant_vld) begin
            mem_addr  <= w_gnt_addr;
            mem_we    <= w_gnt_we;
            mem_wdata <= w_gnt_wdata;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Two-stage id pipeline: stage 1 tracks the RAM cycle, r_ack pulses when read data is out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_id  <= ID_CPU;
            r_ack    <= '0;
        end else begin
            r_s1_vld <= w_grant_vld;
            r_s1_id  <= w_grant_id;
            r_ack    <= '0;
            if (r_s1_vld) begin
                r_ack[r_s1_id] <= 1'b1;
            end
        end
    end

    // Pending bits: set at grant, cleared at the end of the ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~r_ack) | w_grant_oh;
        end
    end

    // Fairness state; reset values make the CPU win the first tie in both modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cl_last_ldr <= 1'b1;
            r_rr_last     <= ID_VID;
        end else if (w_grant_vld) begin
            r_rr_last <= w_grant_id;
            if (w_grant_id == ID_CPU) begin
                r_cl_last_ldr <= 1'b0;
            end else if (w_grant_id == ID_LDR) begin
                r_cl_last_ldr <= 1'b1;
            end
        end
    end

    assign cpu_ack   = r_ack[ID_CPU];
    assign ldr_ack   = r_ack[ID_LDR];
    assign vid_ack   = r_ack[ID_VID];

    // Read data is shared; each port qualifies it with its own ack.
    assign cpu_rdata = mem_rdata;
    assign ldr_rdata = mem_rdata;
    assign vid_rdata = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with video priority, one with
// three-way round-robin, both driven by the same requester stimulus and each
// attached to its own behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;

    logic        vid_ack1, cpu_ack1, ldr_ack1, mem_we1;
    logic [7:0]  vid_rdata1, cpu_rdata1, ldr_rdata1, mem_wdata1, mem_rdata1;
    logic [15:0] mem_addr1;
    logic        vid_ack0, cpu_ack0, ldr_ack0, mem_we0;
    logic [7:0]  vid_rdata0, cpu_rdata0, ldr_rdata0, mem_wdata0, mem_rdata0;
    logic [15:0] mem_addr0;

    logic [7:0]  ram1 [0:65535];
    logic [7:0]  ram0 [0:65535];

    int          n_checks;
    int          n_pass;

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .VIDEO_PRIORITY(1'b1)) u_dut_vp1 (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack1), .vid_rdata(vid_rdata1),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack1), .ldr_rdata(ldr_rdata1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .VIDEO_PRIORITY(1'b0)) u_dut_vp0 (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack0), .vid_rdata(vid_rdata0),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack0), .ldr_rdata(ldr_rdata0),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAMs, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= ram1[mem_addr1];
        if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
        mem_rdata0 <= ram0[mem_addr0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_reqs();
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        cpu_we  = 1'b0; ldr_we  = 1'b0;
    endtask

    // Pulse reset for two cycles; returns at a falling edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        idle_reqs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_ack;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 65536; i++) begin
            ram1[i] = 8'h00;
            ram0[i] = 8'h00;
        end
        vid_addr = '0; cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0;
        reset = 1'b1;
        idle_reqs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_mem_addr",  32'(mem_addr1), 32'h0);
        check("rst_mem_we",    32'(mem_we1), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata1), 32'h0);
        check("rst_acks",      32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        reset = 1'b0;

        // 1: single CPU read, 2-cycle latency, single ack pulse
        ram1[16'h4000] = 8'h5A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        @(negedge clk);
        check("t1_c1_addr", 32'(mem_addr1), 32'h4000);
        check("t1_c1_we",   32'(mem_we1), 32'h0);
        check("t1_c1_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        @(negedge clk);
        check("t1_c2_ack",   32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b001);
        check("t1_c2_rdata", 32'(cpu_rdata1), 32'h5A);
        cpu_req = 1'b0;
        @(negedge clk);
        check("t1_c3_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);

        // 2: video priority, then CPU/loader tie goes to CPU
        do_reset();
        ram1[16'h1000] = 8'h11; ram1[16'h2000] = 8'h22; ram1[16'h3000] = 8'h33;
        vid_req = 1'b1; vid_addr = 16'h1000;
        cpu_req = 1'b1; cpu_addr = 16'h2000;
        ldr_req = 1'b1; ldr_addr = 16'h3000;
        @(negedge clk);
        check("t2_c1_addr", 32'(mem_addr1), 32'h1000);
        check("t2_c1_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        @(negedge clk);
        check("t2_c2_addr", 32'(mem_addr1), 32'h2000);
        check("t2_c2_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b100);
        check("t2_c2_rdata", 32'(vid_rdata1), 32'h11);
        vid_req = 1'b0;
        @(negedge clk);
        check("t2_c3_addr", 32'(mem_addr1), 32'h3000);
        check("t2_c3_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b001);
        check("t2_c3_rdata", 32'(cpu_rdata1), 32'h22);
        cpu_req = 1'b0;
        @(negedge clk);
        check("t2_c4_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b010);
        check("t2_c4_rdata", 32'(ldr_rdata1), 32'h33);
        ldr_req = 1'b0;
        @(negedge clk);
        check("t2_c5_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);

        // 3: loader write then CPU read-back
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h8000; ldr_wdata = 8'hC3;
        @(negedge clk);
        check("t3_c1_we",    32'(mem_we1), 32'h1);
        check("t3_c1_wdata", 32'(mem_wdata1), 32'hC3);
        check("t3_c1_addr",  32'(mem_addr1), 32'h8000);
        @(negedge clk);
        check("t3_c2_we",    32'(mem_we1), 32'h0);
        check("t3_c2_ack",   32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b010);
        ldr_req = 1'b0; ldr_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        @(negedge clk);
        check("t3_c3_addr",  32'(mem_addr1), 32'h8000);
        check("t3_c3_we",    32'(mem_we1), 32'h0);
        @(negedge clk);
        check("t3_c4_ack",   32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b001);
        check("t3_c4_rdata", 32'(cpu_rdata1), 32'hC3);
        cpu_req = 1'b0;

        // 4: CPU and loader continuously requesting: cpu, ldr, idle, repeating
        do_reset();
        cpu_req = 1'b1; cpu_addr = 16'h2000;
        ldr_req = 1'b1; ldr_addr = 16'h3000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_addr = ((k - 1) % 3 == 0) ? 32'h2000 : 32'h3000;
            exp_ack  = (k % 3 == 2) ? 32'b001 : ((k >= 3 && k % 3 == 0) ? 32'b010 : 32'b000);
            check("t4_addr", 32'(mem_addr1), exp_addr);
            check("t4_acks", 32'({vid_ack1, ldr_ack1, cpu_ack1}), exp_ack);
            check("t4_we",   32'(mem_we1), 32'h0);
        end

        // 5: three-way round-robin instance, all held: cpu, ldr, vid repeating
        do_reset();
        ram0[16'h1000] = 8'h11; ram0[16'h2000] = 8'h22; ram0[16'h3000] = 8'h33;
        cpu_req = 1'b1; cpu_addr = 16'h2000;
        ldr_req = 1'b1; ldr_addr = 16'h3000;
        vid_req = 1'b1; vid_addr = 16'h1000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            case ((k - 1) % 3)
                0:       exp_addr = 32'h2000;
                1:       exp_addr = 32'h3000;
                default: exp_addr = 32'h1000;
            endcase
            check("t5_addr", 32'(mem_addr0), exp_addr);
            if (k < 2) exp_ack = 32'b000;
            else if ((k - 2) % 3 == 0) exp_ack = 32'b001;
            else if ((k - 2) % 3 == 1) exp_ack = 32'b010;
            else exp_ack = 32'b100;
            check("t5_acks", 32'({vid_ack0, ldr_ack0, cpu_ack0}), exp_ack);
            if (exp_ack == 32'b001) check("t5_cpu_rdata", 32'(cpu_rdata0), 32'h22);
            if (exp_ack == 32'b010) check("t5_ldr_rdata", 32'(ldr_rdata0), 32'h33);
            if (exp_ack == 32'b100) check("t5_vid_rdata", 32'(vid_rdata0), 32'h11);
        end

        // 6: reset while a CPU write sits on the RAM port
        do_reset();
        ram1[16'h5000] = 8'hAA;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 8'h77;
        @(negedge clk);
        check("t6_c1_we_pre", 32'(mem_we1), 32'h1);
        reset = 1'b1;
        idle_reqs();
        #1;
        check("t6_rst_we",   32'(mem_we1), 32'h0);
        check("t6_rst_acks", 32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        check("t6_rst_addr", 32'(mem_addr1), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_no_ack", 32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        end
        check("t6_ram_untouched", 32'(ram1[16'h5000]), 32'hAA);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
        @(negedge clk);
        check("t6_c1_addr", 32'(mem_addr1), 32'h5000);
        check("t6_c1_ack",  32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'h0);
        @(negedge clk);
        check("t6_c2_ack",   32'({vid_ack1, ldr_ack1, cpu_ack1}), 32'b001);
        check("t6_c2_rdata", 32'(cpu_rdata1), 32'hAA);
        cpu_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
